// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared types and defaults for the SRAM write queue: FSM
//                state encoding, default bus widths and the queued entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int SRAM_ADDR_W = 21;
    localparam int SRAM_DATA_W = 8;

    // Write-cycle sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } wq_state_e;

    // One queued CPU write at the default bus widths
    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
    } wq_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered occupancy. Pushes while
//                full and pops while empty are ignored; a pop does not make
//                room for a same-cycle push when full. Show-ahead read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 29,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, no reset needed: contents are only read when valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : sram_write_queue
//  Description : Queues CPU {address, byte} writes and replays them as timed
//                asynchronous-SRAM write cycles whenever the VGA reader is
//                idle. Outside a write cycle the address bus follows the
//                VGA read address with the SRAM in read mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_write_queue
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int DEPTH_LOG2  = 4,
    parameter int WE_CYCLES   = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  wr_valid,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  clr_ovf,
    input  logic                  vga_idle,
    input  logic [ADDR_W-1:0]     vga_addr,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic                  ovf,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dout,
    output logic                  sram_doe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_MAX = (WE_CYCLES > HOLD_CYCLES) ? WE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    wq_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               doe_q, doe_d;
    logic               ovf_q, ovf_d;

    logic               pop;
    logic               start;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DEPTH_LOG2:0] fifo_level;

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (wr_valid),
        .pop    (pop),
        .din    ({wr_addr, wr_data}),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // A new write cycle may only begin with work queued and the bus released
    assign start = !fifo_empty && vga_idle;

    // Sequencer: next state, head pop/latch, and next values of the pin regs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pop     = 1'b1;
                    addr_d  = fifo_dout[ENTRY_W-1:DATA_W];
                    dout_d  = fifo_dout[DATA_W-1:0];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = STROBE_LOAD;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (start) begin
                    pop     = 1'b1;
                    addr_d  = fifo_dout[ENTRY_W-1:DATA_W];
                    dout_d  = fifo_dout[DATA_W-1:0];
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Pin controls are registered from the next state so they line up
        // with the state register and never glitch
        we_n_d = (state_d != ST_STROBE);
        doe_d  = (state_d != ST_IDLE);
        oe_n_d = (state_d != ST_IDLE);
    end

    // Sticky overflow: an overflowing push wins over a coincident clear
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (wr_valid && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // State and pin registers; reset releases the bus asynchronously
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b0;
            doe_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            doe_q   <= doe_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full      = fifo_full;
    assign level     = fifo_level;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign ovf       = ovf_q;
    assign sram_addr = (state_q == ST_IDLE) ? vga_addr : addr_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_write_queue
//  Description : Self-checking bench for sram_write_queue. A queue-based
//                reference model predicts FIFO occupancy and write-cycle
//                timing; a scoreboard holds the expected SRAM writes in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_write_queue;

    localparam int AW    = 21;
    localparam int DW    = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int WE    = 2;
    localparam int HOLD  = 1;
    localparam int WLEN  = 1 + WE + HOLD;

    logic          clk = 1'b0;
    logic          resetq;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_ovf;
    logic          vga_idle;
    logic [AW-1:0] vga_addr;
    logic          full;
    logic [DL2:0]  level;
    logic          busy;
    logic          ovf;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout;
    logic          sram_doe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    sram_write_queue #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL2),
        .WE_CYCLES(WE), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .resetq(resetq), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr_ovf(clr_ovf), .vga_idle(vga_idle),
        .vga_addr(vga_addr), .full(full), .level(level), .busy(busy),
        .ovf(ovf), .sram_addr(sram_addr), .sram_dout(sram_dout),
        .sram_doe(sram_doe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];      // entries waiting in the queue
    ent_t sb[$];      // writes started, awaiting observation on the pins
    ent_t cur;        // entry of the write cycle in progress
    int   remain = 0; // clocks left in the current write cycle (0 = idle)
    bit   movf = 1'b0;

    always @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            mq.delete();
            sb.delete();
            remain = 0;
            movf   = 1'b0;
        end else begin : step
            int n;
            bit mfull;
            n     = mq.size();
            mfull = (n == DEPTH);
            if (remain <= 1 && n != 0 && vga_idle) begin
                cur = mq.pop_front();
                sb.push_back(cur);
                remain = WLEN;
            end else if (remain > 0) begin
                remain--;
            end
            if (wr_valid && !mfull) mq.push_back('{wr_addr, wr_data});
            if (wr_valid && mfull) movf = 1'b1;
            else if (clr_ovf)     movf = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    bit            prev_we  = 1'b1;
    bit            in_pulse = 1'b0;
    int            width    = 0;
    int            writes   = 0;
    logic [AW-1:0] p_a;
    logic [DW-1:0] p_d;
    ent_t          e;

    always @(negedge clk or negedge resetq) begin
        if (!resetq) begin
            in_pulse = 1'b0;
            prev_we  = 1'b1;
        end
        if (clk == 1'b0) begin
            check("level", 32'(level), 32'(mq.size()));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("ovf", 32'(ovf), 32'(movf));
            check("busy", 32'(busy), 32'(mq.size() != 0 || remain != 0));
            check("we_n", 32'(sram_we_n), 32'(!(remain > HOLD && remain <= HOLD + WE)));
            check("doe", 32'(sram_doe), 32'(remain != 0));
            check("oe_n", 32'(sram_oe_n), 32'(remain != 0));
            check("ce_n", 32'(sram_ce_n), 32'd0);
            check("addr", 32'(sram_addr), 32'((remain == 0) ? vga_addr : cur.a));
            if (remain != 0) check("dout", 32'(sram_dout), 32'(cur.d));
            if (sram_doe && !sram_oe_n) check("doe_vs_oe", 32'(sram_oe_n), 32'd1);
            if (resetq) begin
                if (prev_we && !sram_we_n) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_addr", 32'(sram_addr), 32'(e.a));
                        check("sb_data", 32'(sram_dout), 32'(e.d));
                    end
                    writes++;
                    in_pulse = 1'b1;
                    width    = 1;
                    p_a      = sram_addr;
                    p_d      = sram_dout;
                end else if (!prev_we && !sram_we_n) begin
                    width++;
                    check("addr_stable", 32'(sram_addr), 32'(p_a));
                    check("data_stable", 32'(sram_dout), 32'(p_d));
                end else if (!prev_we && sram_we_n && in_pulse) begin
                    check("we_width", 32'(width), 32'(WE));
                    in_pulse = 1'b0;
                end
                prev_we = sram_we_n;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        vga_addr = AW'($urandom);
        wr_valid = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push(AW'($urandom), DW'($urandom));
    endtask

    task automatic wait_we_low(input int budget);
        int k = 0;
        while (sram_we_n !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        if (sram_we_n !== 1'b0) check("we_low_timeout", 32'(sram_we_n), 32'd0);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        vga_idle = 1'b1;
        while ((mq.size() != 0 || remain != 0) && k < budget) begin
            tick();
            k++;
        end
        check("drain_done", 32'(mq.size() != 0 || remain != 0), 32'd0);
    endtask

    initial begin
        resetq   = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_ovf  = 1'b0;
        vga_idle = 1'b0;
        vga_addr = '0;
        repeat (3) @(posedge clk);
        #2 resetq = 1'b1;
        tick();
        tick();

        // single write
        vga_idle = 1'b1;
        push(21'h00123, 8'hA5);
        repeat (8) tick();
        check("single_writes", 32'(writes), 32'd1);

        // gating on vga_idle
        vga_idle = 1'b0;
        push_rand(3);
        repeat (5) tick();
        check("gate_level", 32'(level), 32'd3);
        check("gate_busy", 32'(busy), 32'd1);
        vga_idle = 1'b1;
        repeat (16) tick();
        check("gate_level_end", 32'(level), 32'd0);
        check("gate_busy_end", 32'(busy), 32'd0);
        check("gate_writes", 32'(writes), 32'd4);

        // overflow
        vga_idle = 1'b0;
        push_rand(17);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_set", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        check("ovf_clr", 32'(ovf), 32'd0);
        drain(100);

        // idle drop during strobe
        vga_idle = 1'b0;
        push_rand(3);
        vga_idle = 1'b1;
        wait_we_low(20);
        vga_idle = 1'b0;
        repeat (10) tick();
        check("drop_level", 32'(level), 32'd2);
        check("drop_busy", 32'(busy), 32'd1);
        drain(40);

        // push on pop cycle at 15 entries, then push when full and popping
        vga_idle = 1'b0;
        push_rand(15);
        vga_idle = 1'b1;
        push_rand(1);
        check("pop15_level", 32'(level), 32'd15);
        check("pop15_ovf", 32'(ovf), 32'd0);
        vga_idle = 1'b0;
        push_rand(1);
        check("fill16_full", 32'(full), 32'd1);
        repeat (6) tick();
        vga_idle = 1'b1;
        push_rand(1);
        check("fullpop_level", 32'(level), 32'd15);
        check("fullpop_ovf", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        drain(100);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            wr_valid = 1'($urandom);
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            clr_ovf  = ($urandom_range(15) == 0);
            if ($urandom_range(19) == 0) vga_idle = ~vga_idle;
            tick();
        end
        drain(100);

        // asynchronous reset during strobe
        push_rand(2);
        wait_we_low(20);
        #1 resetq = 1'b0;
        #1;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_doe", 32'(sram_doe), 32'd0);
        @(posedge clk);
        #2 resetq = 1'b1;
        tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // final drain: every started write must have been seen on the pins
        push_rand(4);
        drain(100);
        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
